// File: rtl/mod13_seg_monitor.sv
// Receive-side checker: decodes active-low 7-segment samples, locks onto the mod-N count, flags/counts sequence errors.
// Latency 1 cycle from a seg_valid sample to every output; no backpressure, state holds while seg_valid=0.
module mod13_seg_monitor #(
  parameter int MODULUS    = 13,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg,
  input  logic             seg_valid,
  output logic [3:0]       value,
  output logic             code_ok,
  output logic             locked,
  output logic             seq_err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [2:0] match_cnt, match_nxt;
  logic [3:0] prev;
  logic [3:0] dec_val;
  logic       dec_hit;
  logic       dec_legal;
  logic [3:0] inc_val;
  logic       is_hold, is_inc, is_err;
  logic       seq_err_nxt, wrap_nxt;
  logic       err_sat;

  always_comb begin
    dec_val = 4'd0;
    dec_hit = 1'b1;
    case (seg)
      7'h40:   dec_val = 4'd0;
      7'h79:   dec_val = 4'd1;
      7'h24:   dec_val = 4'd2;
      7'h30:   dec_val = 4'd3;
      7'h19:   dec_val = 4'd4;
      7'h12:   dec_val = 4'd5;
      7'h02:   dec_val = 4'd6;
      7'h78:   dec_val = 4'd7;
      7'h00:   dec_val = 4'd8;
      7'h10:   dec_val = 4'd9;
      7'h08:   dec_val = 4'd10;
      7'h03:   dec_val = 4'd11;
      7'h46:   dec_val = 4'd12;
      default: dec_hit = 1'b0;
    endcase
  end

  // A glyph that exists but lies outside the configured modulus is treated as garbage.
  assign dec_legal = dec_hit && (dec_val < 4'(MODULUS));
  assign inc_val   = (prev == 4'(MODULUS - 1)) ? 4'd0 : prev + 4'd1;
  assign is_hold   = dec_legal && (dec_val == prev);
  assign is_inc    = dec_legal && !is_hold && (dec_val == inc_val);
  assign is_err    = !is_hold && !is_inc;
  assign err_sat   = &err_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      match_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    if (seg_valid) begin
      case (state)
        HUNT: begin
          if (is_inc) begin
            if (match_cnt + 3'd1 == 3'(LOCK_COUNT)) begin
              state_nxt = LOCKED;
              match_nxt = 3'd0;
            end else begin
              match_nxt = match_cnt + 3'd1;
            end
          end else if (!is_hold) begin
            match_nxt = 3'd0;
          end
        end
        LOCKED: begin
          if (is_err) begin
            state_nxt = HUNT;
            match_nxt = 3'd0;
          end
        end
        default: begin
          state_nxt = HUNT;
          match_nxt = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    seq_err_nxt = 1'b0;
    wrap_nxt    = 1'b0;
    if (seg_valid && state == LOCKED) begin
      seq_err_nxt = is_err;
      wrap_nxt    = is_inc && (prev == 4'(MODULUS - 1));
    end
  end

  assign locked = (state == LOCKED);

  // prev only follows legal samples so an illegal glyph cannot corrupt the reference.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value     <= 4'd0;
      code_ok   <= 1'b0;
      seq_err   <= 1'b0;
      wrap      <= 1'b0;
      err_count <= '0;
      prev      <= 4'd0;
    end else begin
      seq_err <= seq_err_nxt;
      wrap    <= wrap_nxt;
      if (seg_valid) begin
        code_ok <= dec_legal;
        if (dec_legal) begin
          value <= dec_val;
          prev  <= dec_val;
        end
      end
      if (seq_err_nxt && !err_sat) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mod13_seg_monitor.sv
// Directed bench for mod13_seg_monitor: default instance plus an ERR_W=2 instance for saturation.
module tb_mod13_seg_monitor;

  logic       clk;
  logic       reset;
  logic [6:0] seg;
  logic       seg_valid;

  logic [3:0] value, value2;
  logic       code_ok, code_ok2;
  logic       locked, locked2;
  logic       seq_err, seq_err2;
  logic       wrap, wrap2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] codes [0:12] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                               7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46};
  localparam logic [6:0] BLANK = 7'h7F;

  mod13_seg_monitor dut (
    .clk(clk), .reset(reset), .seg(seg), .seg_valid(seg_valid),
    .value(value), .code_ok(code_ok), .locked(locked), .seq_err(seq_err),
    .wrap(wrap), .err_count(err_count)
  );

  mod13_seg_monitor #(.MODULUS(13), .LOCK_COUNT(2), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .seg(seg), .seg_valid(seg_valid),
    .value(value2), .code_ok(code_ok2), .locked(locked2), .seq_err(seq_err2),
    .wrap(wrap2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive at a falling edge; returns at the next falling edge, after the sample was clocked in.
  task automatic drive(input logic [6:0] s, input logic v);
    seg       = s;
    seg_valid = v;
    @(negedge clk);
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    seg_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int nerr;
    int pulses;
    logic [7:0] exp_err;

    reset     = 1'b1;
    seg       = BLANK;
    seg_valid = 1'b0;
    #2;
    check("rst_value", 8'(value), 8'd0);
    check("rst_code_ok", 8'(code_ok), 8'd0);
    check("rst_locked", 8'(locked), 8'd0);
    check("rst_seq_err", 8'(seq_err), 8'd0);
    check("rst_wrap", 8'(wrap), 8'd0);
    check("rst_err_count", err_count, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: 0,1,2 locks after the third sample
    drive(codes[0], 1'b1);
    check("t1_value0", 8'(value), 8'd0);
    check("t1_code_ok0", 8'(code_ok), 8'd1);
    check("t1_locked0", 8'(locked), 8'd0);
    drive(codes[1], 1'b1);
    check("t1_locked1", 8'(locked), 8'd0);
    drive(codes[2], 1'b1);
    check("t1_locked2", 8'(locked), 8'd1);
    check("t1_value2", 8'(value), 8'd2);
    check("t1_seq_err", 8'(seq_err), 8'd0);

    // 2: run to 12 then wrap to 0
    for (int v = 3; v <= 12; v++) begin
      drive(codes[v], 1'b1);
      check("t2_wrap_early", 8'(wrap), 8'd0);
      check("t2_locked", 8'(locked), 8'd1);
    end
    check("t2_value12", 8'(value), 8'd12);
    drive(codes[0], 1'b1);
    check("t2_wrap", 8'(wrap), 8'd1);
    check("t2_value0", 8'(value), 8'd0);
    check("t2_locked_wrap", 8'(locked), 8'd1);
    check("t2_err_count", err_count, 8'd0);
    drive(codes[1], 1'b1);
    check("t2_wrap_once", 8'(wrap), 8'd0);

    // 3: locked at 5, jump to 3, relock with 4,5
    for (int v = 2; v <= 5; v++) drive(codes[v], 1'b1);
    check("t3_locked5", 8'(locked), 8'd1);
    check("t3_value5", 8'(value), 8'd5);
    drive(codes[3], 1'b1);
    check("t3_seq_err", 8'(seq_err), 8'd1);
    check("t3_err_count", err_count, 8'd1);
    check("t3_unlocked", 8'(locked), 8'd0);
    check("t3_value3", 8'(value), 8'd3);
    drive(codes[4], 1'b1);
    check("t3_seq_err_clr", 8'(seq_err), 8'd0);
    check("t3_hunt4", 8'(locked), 8'd0);
    drive(codes[5], 1'b1);
    check("t3_relock", 8'(locked), 8'd1);

    // 4: locked at 7, blank pattern, then 8
    pulse_reset();
    drive(codes[5], 1'b1);
    drive(codes[6], 1'b1);
    drive(codes[7], 1'b1);
    check("t4_locked7", 8'(locked), 8'd1);
    check("t4_err_pre", err_count, 8'd0);
    drive(BLANK, 1'b1);
    check("t4_code_bad", 8'(code_ok), 8'd0);
    check("t4_value_hold", 8'(value), 8'd7);
    check("t4_seq_err", 8'(seq_err), 8'd1);
    check("t4_err_count", err_count, 8'd1);
    check("t4_unlocked", 8'(locked), 8'd0);
    drive(codes[8], 1'b1);
    check("t4_code_ok8", 8'(code_ok), 8'd1);
    check("t4_value8", 8'(value), 8'd8);
    check("t4_hunt8", 8'(locked), 8'd0);
    check("t4_seq_err_clr", 8'(seq_err), 8'd0);

    // 5: holds while locked, then seg_valid low freezes everything
    drive(codes[9], 1'b1);
    check("t5_locked", 8'(locked), 8'd1);
    repeat (5) begin
      drive(codes[9], 1'b1);
      check("t5_hold_seq_err", 8'(seq_err), 8'd0);
      check("t5_hold_locked", 8'(locked), 8'd1);
    end
    drive(BLANK, 1'b0);
    drive(codes[3], 1'b0);
    drive(codes[0], 1'b0);
    check("t5_frz_value", 8'(value), 8'd9);
    check("t5_frz_code_ok", 8'(code_ok), 8'd1);
    check("t5_frz_locked", 8'(locked), 8'd1);
    check("t5_frz_seq_err", 8'(seq_err), 8'd0);
    check("t5_frz_err", err_count, 8'd1);
    drive(codes[10], 1'b1);
    check("t5_resume", 8'(value), 8'd10);
    check("t5_resume_lock", 8'(locked), 8'd1);

    // 6: five errors into a 2-bit counter, then asynchronous reset mid-lock
    pulse_reset();
    nerr   = 0;
    pulses = 0;
    drive(codes[0], 1'b1);
    drive(codes[1], 1'b1);
    drive(codes[2], 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(BLANK, 1'b1);
      nerr++;
      if (seq_err2) pulses++;
      exp_err = (nerr > 3) ? 8'd3 : 8'(nerr);
      check("t6_err_count2", 8'(err_count2), exp_err);
      drive(codes[3 + 2 * k], 1'b1);
      if (seq_err2) pulses++;
      drive(codes[4 + 2 * k], 1'b1);
      if (seq_err2) pulses++;
      check("t6_relock", 8'(locked2), 8'd1);
    end
    check("t6_pulses", 8'(pulses), 8'd5);
    check("t6_err_sat", 8'(err_count2), 8'd3);
    check("t6_err_wide", err_count, 8'd5);
    drive(codes[13 - 1], 1'b1);
    check("t6_hold_value", 8'(value2), 8'd12);

    #2;
    reset = 1'b1;
    #1;
    check("t6_ar_value", 8'(value2), 8'd0);
    check("t6_ar_code_ok", 8'(code_ok2), 8'd0);
    check("t6_ar_locked", 8'(locked2), 8'd0);
    check("t6_ar_seq_err", 8'(seq_err2), 8'd0);
    check("t6_ar_wrap", 8'(wrap2), 8'd0);
    check("t6_ar_err2", 8'(err_count2), 8'd0);
    check("t6_ar_err1", err_count, 8'd0);
    check("t6_ar_locked1", 8'(locked), 8'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
